// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle timing engine for the multiplexed-bus RTC: one start edge yields an address phase then a data phase.
// Optional read-data capture register is enabled by defining RTC_SEQ_DATA_LATCH_EN.
module rtc_bus_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_PW    = 10,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 8,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef RTC_SEQ_DATA_LATCH_EN
    input  logic [7:0] bus_in,
    output logic [7:0] rd_data,
`endif
    input  logic       start,
    input  logic       wr_nrd,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       addr_drive,
    output logic       data_drive,
    output logic       fetch,
    output logic       done,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic               start_q, op_wr, nxt_op, accept;
    logic               n_ad, n_cs, n_rd, n_wr, n_addr, n_data, n_fetch, n_done, n_busy;

    function automatic state_t succ(input state_t s);
        case (s)
            IDLE:    return A_SU;
            A_SU:    return A_PW;
            A_PW:    return A_HD;
            A_HD:    return GAP;
            GAP:     return D_SU;
            D_SU:    return D_PW;
            D_PW:    return D_HD;
            D_HD:    return DONE;
            default: return IDLE;
        endcase
    endfunction

    function automatic int dur(input state_t s);
        case (s)
            A_SU, D_SU: return T_SETUP;
            A_PW, D_PW: return T_PW;
            A_HD, D_HD: return T_HOLD;
            GAP:        return T_GAP;
            default:    return 1;
        endcase
    endfunction

    // At most three zero-length states can sit back to back (A_HD, GAP, D_SU).
    function automatic state_t advance(input state_t s);
        state_t n;
        n = succ(s);
        for (int i = 0; i < 3; i++) begin
            if (dur(n) == 0) n = succ(n);
        end
        return n;
    endfunction

    always_comb begin
        accept    = (state == IDLE) && start && !start_q;
        nxt_op    = accept ? wr_nrd : op_wr;
        nxt_state = state;
        nxt_cnt   = '0;
        case (state)
            IDLE: if (accept) nxt_state = advance(IDLE);
            DONE: nxt_state = IDLE;
            default: begin
                if (int'(cnt) >= dur(state) - 1) nxt_state = advance(state);
                else                              nxt_cnt   = cnt + CNT_W'(1);
            end
        endcase

        n_ad   = 1'b1;
        n_cs   = 1'b1;
        n_rd   = 1'b1;
        n_wr   = 1'b1;
        n_addr = 1'b0;
        n_data = 1'b0;
        n_done = 1'b0;
        n_busy = (nxt_state != IDLE);
        case (nxt_state)
            A_SU, A_HD: begin
                n_ad   = 1'b0;
                n_cs   = 1'b0;
                n_addr = 1'b1;
            end
            A_PW: begin
                n_ad   = 1'b0;
                n_cs   = 1'b0;
                n_wr   = 1'b0;
                n_addr = 1'b1;
            end
            D_SU, D_HD: begin
                n_cs   = 1'b0;
                n_data = nxt_op;
            end
            D_PW: begin
                n_cs   = 1'b0;
                n_wr   = !nxt_op;
                n_rd   = nxt_op;
                n_data = nxt_op;
            end
            DONE:    n_done = 1'b1;
            default: ;
        endcase
        // Strobe the capture on the final pulse cycle so the bus is still being driven by the RTC.
        n_fetch = (nxt_state == D_PW) && !nxt_op && (int'(nxt_cnt) == T_PW - 1);
    end

    // Tracking start during reset means a start held high across release is not seen as an edge.
    always_ff @(posedge clk) begin
        start_q <= start;
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            AD         <= 1'b1;
            CS         <= 1'b1;
            RD         <= 1'b1;
            WR         <= 1'b1;
            addr_drive <= 1'b0;
            data_drive <= 1'b0;
            fetch      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
`ifdef RTC_SEQ_DATA_LATCH_EN
            rd_data    <= 8'h00;
`endif
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            op_wr      <= nxt_op;
            AD         <= n_ad;
            CS         <= n_cs;
            RD         <= n_rd;
            WR         <= n_wr;
            addr_drive <= n_addr;
            data_drive <= n_data;
            fetch      <= n_fetch;
            done       <= n_done;
            busy       <= n_busy;
`ifdef RTC_SEQ_DATA_LATCH_EN
            if (fetch) rd_data <= bus_in;
`endif
        end
    end

endmodule
